wb_reg_sequencer: RTL and testbench

//  Multicycle write-back sequencer for the register-file write port. Latches opcode/funct at

---
 rtl/wb_reg_sequencer_if.sv | 24 ++
 rtl/wb_reg_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_wb_reg_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/wb_reg_sequencer_if.sv
// Bus between main control and the write-back sequencer.
interface wb_reg_sequencer_if;
  logic       start;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       alu_done;
  logic [1:0] wr_sel;
  logic       reg_write;
  logic       busy;
  logic       done;
  logic       illegal_op;
  logic       timeout_err;

  modport master (
    output start, opcode, funct, mem_ready, alu_done,
    input  wr_sel, reg_write, busy, done, illegal_op, timeout_err
  );

  modport slave (
    input  start, opcode, funct, mem_ready, alu_done,
    output wr_sel, reg_write, busy, done, illegal_op, timeout_err
  );
endinterface

// File: rtl/wb_reg_sequencer.sv
// Multicycle write-back sequencer owning every register-file write.
// Outputs are registered from the next-state decode so they line up with the state.
module wb_reg_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter logic [5:0]  PUSH_OP     = 6'h3C,
  parameter logic [5:0]  POP_OP      = 6'h3D
) (
  input  logic             clk,
  input  logic             reset,
  wb_reg_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = 5;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_EXEC     = 4'd1;
  localparam logic [3:0] S_MEM_WAIT = 4'd2;
  localparam logic [3:0] S_WB_RT    = 4'd3;
  localparam logic [3:0] S_WB_RD    = 4'd4;
  localparam logic [3:0] S_WB_31    = 4'd5;
  localparam logic [3:0] S_WB_SP    = 4'd6;
  localparam logic [3:0] S_ALU_WAIT = 4'd7;
  localparam logic [3:0] S_FIN      = 4'd8;
  localparam logic [3:0] S_ERR      = 4'd9;

  localparam logic [3:0] C_RALU   = 4'd0;
  localparam logic [3:0] C_IALU   = 4'd1;
  localparam logic [3:0] C_JAL    = 4'd2;
  localparam logic [3:0] C_LOAD   = 4'd3;
  localparam logic [3:0] C_POP    = 4'd4;
  localparam logic [3:0] C_PUSH   = 4'd5;
  localparam logic [3:0] C_STORE  = 4'd6;
  localparam logic [3:0] C_MULDIV = 4'd7;
  localparam logic [3:0] C_NOWB   = 4'd8;
  localparam logic [3:0] C_ILL    = 4'd9;

  logic [3:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [5:0]       op_q, op_nxt;
  logic [5:0]       fn_q, fn_nxt;
  logic [3:0]       cls;

  logic [1:0] wr_sel_q, wr_sel_nxt;
  logic       reg_write_q, reg_write_nxt;
  logic       busy_q, busy_nxt;
  logic       done_q, done_nxt;
  logic       illegal_q, illegal_nxt;
  logic       timeout_q, timeout_nxt;

  // Instruction class of a latched opcode/funct pair.
  function automatic logic [3:0] classify(input logic [5:0] op, input logic [5:0] fn);
    logic [3:0] c;
    if (op == PUSH_OP)     c = C_PUSH;
    else if (op == POP_OP) c = C_POP;
    else begin
      case (op)
        6'h00: begin
          case (fn)
            6'h08:        c = C_NOWB;
            6'h18, 6'h1A: c = C_MULDIV;
            default:      c = C_RALU;
          endcase
        end
        6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F: c = C_IALU;
        6'h03:                      c = C_JAL;
        6'h02, 6'h04, 6'h05:        c = C_NOWB;
        6'h20, 6'h21, 6'h23:        c = C_LOAD;
        6'h28, 6'h29, 6'h2B:        c = C_STORE;
        default:                    c = C_ILL;
      endcase
    end
    return c;
  endfunction

  assign cls = classify(op_q, fn_q);

  // Next state, wait counter, instruction latch and next-cycle output values.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    op_nxt        = op_q;
    fn_nxt        = fn_q;
    wr_sel_nxt    = 2'b00;
    reg_write_nxt = 1'b0;
    done_nxt      = 1'b0;
    illegal_nxt   = 1'b0;
    timeout_nxt   = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = S_EXEC;
          op_nxt    = bus.opcode;
          fn_nxt    = bus.funct;
        end
      end
      S_EXEC: begin
        cnt_nxt = '0;
        case (cls)
          C_RALU:                 state_nxt = S_WB_RD;
          C_IALU:                 state_nxt = S_WB_RT;
          C_JAL:                  state_nxt = S_WB_31;
          C_PUSH:                 state_nxt = S_WB_SP;
          C_LOAD, C_POP, C_STORE: state_nxt = S_MEM_WAIT;
          C_MULDIV:               state_nxt = S_ALU_WAIT;
          C_NOWB:                 state_nxt = S_FIN;
          default: begin
            state_nxt   = S_ERR;
            illegal_nxt = 1'b1;
          end
        endcase
      end
      S_MEM_WAIT: begin
        if (bus.mem_ready) begin
          state_nxt = (cls == C_STORE) ? S_FIN : S_WB_RT;
        end else if (cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
          state_nxt   = S_ERR;
          timeout_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_WB_RT:    state_nxt = (cls == C_POP) ? S_WB_SP : S_IDLE;
      S_WB_RD, S_WB_31, S_WB_SP, S_FIN, S_ERR: state_nxt = S_IDLE;
      S_ALU_WAIT: if (bus.alu_done) state_nxt = S_FIN;
      default:    state_nxt = S_IDLE;
    endcase

    case (state_nxt)
      S_WB_RT: begin
        reg_write_nxt = 1'b1;
        wr_sel_nxt    = 2'b00;
        done_nxt      = (cls != C_POP);
      end
      S_WB_RD: begin
        reg_write_nxt = 1'b1;
        wr_sel_nxt    = 2'b11;
        done_nxt      = 1'b1;
      end
      S_WB_31: begin
        reg_write_nxt = 1'b1;
        wr_sel_nxt    = 2'b10;
        done_nxt      = 1'b1;
      end
      S_WB_SP: begin
        reg_write_nxt = 1'b1;
        wr_sel_nxt    = 2'b01;
        done_nxt      = 1'b1;
      end
      S_FIN, S_ERR: done_nxt = 1'b1;
      default: ;
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  // State, latch and output registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      op_q        <= '0;
      fn_q        <= '0;
      wr_sel_q    <= 2'b00;
      reg_write_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      op_q        <= op_nxt;
      fn_q        <= fn_nxt;
      wr_sel_q    <= wr_sel_nxt;
      reg_write_q <= reg_write_nxt;
      busy_q      <= busy_nxt;
      done_q      <= done_nxt;
      illegal_q   <= illegal_nxt;
      timeout_q   <= timeout_nxt;
    end
  end

  assign bus.wr_sel      = wr_sel_q;
  assign bus.reg_write   = reg_write_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.illegal_op  = illegal_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_wb_reg_sequencer.sv
// Self-checking bench for wb_reg_sequencer: per-cycle timeline model versus DUT outputs.
module tb_wb_reg_sequencer;

  localparam int unsigned MT   = 16;
  localparam logic [5:0]  PUSH = 6'h3C;
  localparam logic [5:0]  POP  = 6'h3D;
  localparam logic [5:0]  OPS [16] = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h03,
                                       6'h20, 6'h23, PUSH, POP, 6'h2B, 6'h28, 6'h02, 6'h04};
  localparam logic [5:0]  FNS [5] = '{6'h08, 6'h18, 6'h1A, 6'h20, 6'h22};

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  logic [6:0] obs;

  wb_reg_sequencer_if bus_i ();

  wb_reg_sequencer #(.MEM_TIMEOUT(MT), .PUSH_OP(PUSH), .POP_OP(POP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_i)
  );

  always #5 clk = ~clk;

  assign obs = {bus_i.busy, bus_i.reg_write, bus_i.wr_sel, bus_i.done,
                bus_i.illegal_op, bus_i.timeout_err};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Timeline of one instruction, in cycles after the start cycle T0.
  task automatic model(input logic [5:0] op, input logic [5:0] fn, input int n, input int m,
                       output int last, output int w0, output int w1,
                       output logic [1:0] s0, output logic [1:0] s1,
                       output logic ill, output logic tmo);
    last = 2; w0 = -1; w1 = -1; s0 = 2'b00; s1 = 2'b00; ill = 1'b0; tmo = 1'b0;
    if (op == PUSH) begin
      w0 = 2; s0 = 2'b01;
    end else if (op == POP) begin
      if (n >= int'(MT)) begin tmo = 1'b1; last = 2 + int'(MT); end
      else begin w0 = 3 + n; s0 = 2'b00; w1 = 4 + n; s1 = 2'b01; last = 4 + n; end
    end else if (op == 6'h00) begin
      if (fn == 6'h08) begin end
      else if (fn inside {6'h18, 6'h1A}) last = 3 + m;
      else begin w0 = 2; s0 = 2'b11; end
    end else if (op inside {6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F}) begin
      w0 = 2; s0 = 2'b00;
    end else if (op == 6'h03) begin
      w0 = 2; s0 = 2'b10;
    end else if (op inside {6'h02, 6'h04, 6'h05}) begin
    end else if (op inside {6'h20, 6'h21, 6'h23}) begin
      if (n >= int'(MT)) begin tmo = 1'b1; last = 2 + int'(MT); end
      else begin w0 = 3 + n; s0 = 2'b00; last = 3 + n; end
    end else if (op inside {6'h28, 6'h29, 6'h2B}) begin
      if (n >= int'(MT)) begin tmo = 1'b1; last = 2 + int'(MT); end
      else last = 3 + n;
    end else begin
      ill = 1'b1;
    end
  endtask

  // Issue one instruction: mem_ready low for n wait cycles, alu_done after m cycles,
  // random start/opcode noise while busy; compare every cycle and the write count.
  task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn,
                     input int n, input int m);
    int last, w0, w1, wr_seen, wr_exp;
    logic [1:0] s0, s1;
    logic ill, tmo;
    logic [6:0] exp;
    model(op, fn, n, m, last, w0, w1, s0, s1, ill, tmo);
    wr_exp  = int'(w0 >= 0) + int'(w1 >= 0);
    wr_seen = 0;
    bus_i.start     = 1'b1;
    bus_i.opcode    = op;
    bus_i.funct     = fn;
    bus_i.mem_ready = 1'($urandom);
    bus_i.alu_done  = 1'($urandom);
    for (int k = 1; k <= last + 1; k++) begin
      @(negedge clk);
      exp = {k <= last, (k == w0) || (k == w1),
             (k == w0) ? s0 : ((k == w1) ? s1 : 2'b00),
             k == last, ill && (k == last), tmo && (k == last)};
      check($sformatf("%s cyc%0d", name, k), 32'(obs), 32'(exp));
      if (bus_i.reg_write) wr_seen++;
      bus_i.start     = (k <= last) ? 1'($urandom) : 1'b0;
      bus_i.opcode    = 6'($urandom);
      bus_i.funct     = 6'($urandom);
      bus_i.mem_ready = (k >= 2) ? (k >= 2 + n) : 1'($urandom);
      bus_i.alu_done  = (k >= 2) ? (k >= 2 + m) : 1'($urandom);
    end
    check($sformatf("%s writes", name), 32'(wr_seen), 32'(wr_exp));
  endtask

  initial begin
    logic [5:0] op, fn;
    bus_i.start     = 1'b0;
    bus_i.opcode    = 6'h00;
    bus_i.funct     = 6'h00;
    bus_i.mem_ready = 1'b0;
    bus_i.alu_done  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset outputs", 32'(obs), 32'(0));
    reset = 1'b0;

    run("add",        6'h00, 6'h20, 0, 0);
    run("lw_wait3",   6'h23, 6'h00, 3, 0);
    run("pop",        POP,   6'h00, 0, 0);
    run("jal",        6'h03, 6'h00, 0, 0);
    run("illegal",    6'h3F, 6'h00, 0, 0);
    run("sw_timeout", 6'h2B, 6'h00, 40, 0);
    run("lw_edge",    6'h20, 6'h00, int'(MT) - 1, 0);
    run("lw_timeout", 6'h21, 6'h00, int'(MT), 0);
    run("push",       PUSH,  6'h00, 0, 0);
    run("sw_fast",    6'h28, 6'h00, 0, 0);
    run("mult",       6'h00, 6'h18, 0, 4);
    run("jr",         6'h00, 6'h08, 0, 0);
    run("beq",        6'h04, 6'h00, 0, 0);

    // Reset during a load's memory wait aborts with no write.
    bus_i.start  = 1'b1;
    bus_i.opcode = 6'h23;
    bus_i.funct  = 6'h00;
    bus_i.mem_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("rst_lw cyc%0d", k), 32'(obs), 32'(7'b1000000));
      bus_i.start     = 1'($urandom);
      bus_i.mem_ready = 1'b0;
    end
    #2;
    reset       = 1'b1;
    bus_i.start = 1'b0;
    #1;
    check("async reset", 32'(obs), 32'(0));
    @(negedge clk);
    check("held reset", 32'(obs), 32'(0));
    reset = 1'b0;
    run("after_reset", 6'h0D, 6'h00, 0, 0);

    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : OPS[$urandom_range(0, 15)];
      fn = (op == 6'h00 && $urandom_range(0, 1) == 1) ? FNS[$urandom_range(0, 4)]
                                                      : 6'($urandom);
      run($sformatf("rnd%0d", i), op, fn, int'($urandom_range(0, 20)),
          int'($urandom_range(0, 6)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
